// File: rtl/alu_sequencer_if.sv
// Bundles the instruction handshake and the ALU operand/result bus of alu_sequencer.
// master: instruction source plus external ALU; slave: the sequencer itself.
interface alu_sequencer_if #(
    parameter int DATA_W = 4,
    parameter int AW     = 2
);
    logic              valid;
    logic              ready;
    logic [2:0]        op;
    logic [AW-1:0]     rd;
    logic [AW-1:0]     rs;
    logic [AW-1:0]     rt;
    logic              imm_en;
    logic [DATA_W-1:0] imm;
    logic [2:0]        control;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] result;
    logic              zero;

    modport master (
        output valid, op, rd, rs, rt, imm_en, imm, result, zero,
        input  ready, control, a, b
    );

    modport slave (
        input  valid, op, rd, rs, rt, imm_en, imm, result, zero,
        output ready, control, a, b
    );
endinterface

// File: rtl/alu_sequencer.sv
// Three-cycle instruction sequencer: reads a small register file, drives an external
// combinational ALU for one cycle, then writes the result back.
module alu_sequencer #(
    parameter int DATA_W = 4,
    parameter int NREG   = 4,
    parameter int AW     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_sequencer_if.slave    io_bus,
    output logic              o_done,
    output logic [DATA_W-1:0] o_done_result,
    output logic              o_zero_flag,
    input  logic [AW-1:0]     i_dbg_addr,
    output logic [DATA_W-1:0] o_dbg_data
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [DATA_W-1:0] r_regs [NREG];
    logic [2:0]        r_ctrl;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [AW-1:0]     r_rd;
    logic [DATA_W-1:0] r_res;
    logic              r_zero_cap;
    logic              r_zero_flag;
    logic [DATA_W-1:0] w_opa;
    logic [DATA_W-1:0] w_opb;

    // r0 is forced to zero on every read path, independent of array contents
    always_comb begin
        w_opa      = (io_bus.rs == '0) ? '0 : r_regs[io_bus.rs];
        w_opb      = io_bus.imm_en ? io_bus.imm
                   : ((io_bus.rt == '0) ? '0 : r_regs[io_bus.rt]);
        o_dbg_data = (i_dbg_addr == '0) ? '0 : r_regs[i_dbg_addr];
    end

    always_comb begin
        w_next       = r_state;
        io_bus.ready = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                io_bus.ready = 1'b1;
                if (io_bus.valid) w_next = S_EXEC;
            end
            S_EXEC: w_next = S_WB;
            S_WB: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
            r_ctrl      <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rd        <= '0;
            r_res       <= '0;
            r_zero_cap  <= 1'b0;
            r_zero_flag <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                // operand latches double as the registered ALU drive and hold afterwards
                S_IDLE: begin
                    if (io_bus.valid) begin
                        r_ctrl <= io_bus.op;
                        r_a    <= w_opa;
                        r_b    <= w_opb;
                        r_rd   <= io_bus.rd;
                    end
                end
                S_EXEC: begin
                    r_res      <= io_bus.result;
                    r_zero_cap <= io_bus.zero;
                end
                S_WB: begin
                    if (r_rd != '0) r_regs[r_rd] <= r_res;
                    r_zero_flag <= r_zero_cap;
                end
                default: ;
            endcase
        end
    end

    assign io_bus.control = r_ctrl;
    assign io_bus.a       = r_a;
    assign io_bus.b       = r_b;
    assign o_done_result  = r_res;
    assign o_zero_flag    = r_zero_flag;
endmodule
